divisor_restoring: RTL and testbench
====================================

Name: divisor_restoring

Overview:
Parametrised sequential integer divider; successor to the 4-bit repeated-subtraction divider in the ALU.
- Restoring shift-subtract algorithm, one quotient bit per cycle.
- Fixed latency independent of operand values.
- Returns both quotient and remainder, with an explicit divide-by-zero flag and a start/busy/done handshake.
- Sits beside the adder/multiplier in the ALU datapath; the ALU controller drives it.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (>= 2)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high; clock clk
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when results become valid
quotient  output  WIDTH  result, held until next accepted start
remainder  output  WIDTH  result, held until next accepted start
div_by_zero  output  1  set with done when captured divisor == 0; held with results

Behaviour:
- Reset (any state, including mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Any in-flight operation is discarded and no done pulse is issued.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On start=1 (cycle T), capture dividend and divisor into internal registers.
  - Clear step counter; clear div_by_zero.
  - If captured divisor==0, go to FINISH; otherwise go to RUN.
  - Operand inputs are don't-care after cycle T.
- RUN: exactly WIDTH cycles (T+1..T+WIDTH). Each cycle:
  - Shift the {partial_rem[WIDTH:0], quo[WIDTH-1:0]} pair left by 1.
  - Trial = partial_rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: partial_rem = trial and quo LSB = 1; else restore and LSB = 0.
  - Counter increments; after step WIDTH-1 go to FINISH.
- FINISH (cycle T+WIDTH+1):
  - Normal case: load quotient=quo and remainder=partial_rem[WIDTH-1:0].
  - Divide-by-zero case: quotient = all ones, remainder = captured dividend, div_by_zero=1.
  - done=1 for this cycle only; next state IDLE.
- Latency:
  - Normal: done at T+WIDTH+1.
  - Divide-by-zero: done at T+1.
  - Back-to-back: a new start is accepted at the earliest in the cycle after done.
- busy=1 from T+1 through the done cycle inclusive.
- start while busy: ignored, no queuing, captured operands unaffected.
- Outputs change only in FINISH or on reset; they are stable between operations.
- Arithmetic:
  - Unsigned; invariant dividend = quotient*divisor + remainder, with remainder < divisor.
  - No overflow possible in unsigned mode.
- Boundaries:
  - dividend < divisor -> quotient=0, remainder=dividend.
  - divisor=1 -> quotient=dividend, remainder=0.
  - dividend=0 -> quotient=0, remainder=0 (full latency still applies).

Optional Feature:
DIVISOR_SIGNED_EN
- Defined:
  - Adds input port signed_mode (1 bit), sampled with start.
  - When signed_mode=1, operands are two's complement and magnitudes are divided by the unsigned core.
  - Quotient sign = dividend sign XOR divisor sign; remainder takes the dividend's sign (truncating division).
  - Sign fix-up is registered in FINISH, so latency is unchanged.
  - Most-negative / -1: quotient = most-negative value (wraps), remainder=0, div_by_zero=0.
  - Divide-by-zero in signed mode: same outputs as unsigned.
  - signed_mode=0 behaves exactly as the unsigned build.
- Undefined: port absent; unsigned only.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, RUN, FINISH);
  - localparam for the divide-by-zero quotient code (all ones);
  - function for the counter width, $clog2(WIDTH).
- No sub-module for the unsigned core; the datapath and FSM stay in one module.
- With DIVISOR_SIGNED_EN, a small combinational sub-module div_sign_fix handles magnitude conversion and result sign restoration.

Test Plan:
- WIDTH=8, start with 100/7 at T -> busy T+1..T+9; done at T+9 only; quotient=14, remainder=2, div_by_zero=0.
- 5/0 -> done at T+1; quotient=0xFF, remainder=5, div_by_zero=1; next start with 6/3 clears the flag -> quotient=2, remainder=0.
- 3/9 -> quotient=0, remainder=3. 255/1 -> quotient=255, remainder=0. 0/13 -> quotient=0, remainder=0 at T+9.
- Start 200/10; pulse start with 9/3 at T+4 -> ignored; result quotient=20, remainder=0 at T+9; no second done.
- Start 200/10; reset at T+4 -> outputs 0 next cycle, busy=0, no done pulse; fresh 17/5 then gives quotient=3, remainder=2.
- DIVISOR_SIGNED_EN, signed_mode=1:
  - -7/2 -> quotient=-3, remainder=-1.
  - 7/-2 -> quotient=-3, remainder=1.
  - -128/-1 -> quotient=-128, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
// Pure declarations: no latency, no flow control.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Quotient reported on divide-by-zero; slice to the operand width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Two's-complement magnitude extraction and result sign restoration; combinational.
// Zero latency; no flow control.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] dividend_mag_o,
  output logic [WIDTH-1:0] divisor_mag_o,
  output logic             quo_neg_o,
  output logic             rem_neg_o,
  input  logic             quo_neg_i,
  input  logic             rem_neg_i,
  input  logic [WIDTH-1:0] quo_mag_i,
  input  logic [WIDTH-1:0] rem_mag_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic a_neg, b_neg;

  assign a_neg = signed_mode_i & dividend_i[WIDTH-1];
  assign b_neg = signed_mode_i & divisor_i[WIDTH-1];

  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign dividend_mag_o = a_neg ? -dividend_i : dividend_i;
  assign divisor_mag_o  = b_neg ? -divisor_i  : divisor_i;
  assign quo_neg_o      = a_neg ^ b_neg;
  assign rem_neg_o      = a_neg;

  assign quotient_o  = quo_neg_i ? -quo_mag_i : quo_mag_i;
  assign remainder_o = rem_neg_i ? -rem_mag_i : rem_mag_i;

endmodule

// File: rtl/divisor_restoring.sv
// Restoring shift-subtract divider, one quotient bit per cycle; done at T+WIDTH+1 (T+1 on /0).
// start is honoured only in IDLE; DIVISOR_SIGNED_EN adds signed_mode_i for two's-complement operands.
module divisor_restoring #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DIVISOR_SIGNED_EN
  input  logic             signed_mode_i,
`endif
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);
  import div_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] dvnd_mag, dvsr_mag, quo_fix, rem_fix;

  // The dividend is loaded into quo_q and shifted out of its MSB into the partial remainder.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    rem_d   = shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

`ifdef DIVISOR_SIGNED_EN
  logic qneg_d, rneg_d, qneg_q, rneg_q;

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_mode_i  (signed_mode_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .dividend_mag_o (dvnd_mag),
    .divisor_mag_o  (dvsr_mag),
    .quo_neg_o      (qneg_d),
    .rem_neg_o      (rneg_d),
    .quo_neg_i      (qneg_q),
    .rem_neg_i      (rneg_q),
    .quo_mag_i      (quo_d),
    .rem_mag_i      (rem_d),
    .quotient_o     (quo_fix),
    .remainder_o    (rem_fix)
  );
`else
  assign dvnd_mag = dividend_i;
  assign dvsr_mag = divisor_i;
  assign quo_fix  = quo_d;
  assign rem_fix  = rem_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVISOR_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            quo_q  <= dvnd_mag;
            dvsr_q <= dvsr_mag;
            rem_q  <= '0;
            cnt_q  <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef DIVISOR_SIGNED_EN
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
`endif
            if (divisor_i == '0) begin
              state_q     <= FINISH;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= DBZ_QUOTIENT[WIDTH-1:0];
              remainder_q <= dividend_i;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          // Results are registered on entry to FINISH so they are valid alongside done.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= FINISH;
            done_q      <= 1'b1;
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divisor_restoring.sv
// Directed and random bench for divisor_restoring against an arithmetic reference model.
module tb_divisor_restoring;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic         signed_mode_i;
  logic [W-1:0] dividend_i, divisor_i;
  logic         busy_o, done_o, div_by_zero_o;
  logic [W-1:0] quotient_o, remainder_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divisor_restoring #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef DIVISOR_SIGNED_EN
    .signed_mode_i (signed_mode_i),
`endif
    .start_i       (start_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    start_i       = 1'b1;
    dividend_i    = a;
    divisor_i     = b;
    signed_mode_i = sm;
    step;
    start_i       = 1'b0;
    dividend_i    = W'($urandom);
    divisor_i     = W'($urandom);
    signed_mode_i = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm, input int lat0);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(a, b, sm, eq, er, ez);
    lat = lat0;
    while (done_o !== 1'b1 && lat < 3 * W) begin
      check({tag, " busy"}, 32'(busy_o), 32'd1);
      step;
      lat++;
    end
    check({tag, " busy@done"}, 32'(busy_o), 32'd1);
    check({tag, " latency"}, lat, ez ? 32'd1 : 32'(W + 1));
    check({tag, " quotient"}, 32'(quotient_o), 32'(eq));
    check({tag, " remainder"}, 32'(remainder_o), 32'(er));
    check({tag, " dbz"}, 32'(div_by_zero_o), 32'(ez));
    step;
    check({tag, " done pulse"}, 32'(done_o), 32'd0);
    check({tag, " busy after"}, 32'(busy_o), 32'd0);
    check({tag, " held q"}, 32'(quotient_o), 32'(eq));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm);
    launch(a, b, sm);
    wait_done(tag, a, b, sm, 1);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, " no done"}, 32'(done_o), 32'd0);
      check({tag, " idle"}, 32'(busy_o), 32'd0);
      step;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    logic         sm;

    reset = 1'b1;
    start_i = 1'b0;
    signed_mode_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    step; step; step;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset quotient", 32'(quotient_o), 32'd0);
    check("reset remainder", 32'(remainder_o), 32'd0);
    check("reset dbz", 32'(div_by_zero_o), 32'd0);
    reset = 1'b0;
    step;

    do_op("100/7", 8'd100, 8'd7, 1'b0);
    do_op("5/0", 8'd5, 8'd0, 1'b0);
    do_op("6/3", 8'd6, 8'd3, 1'b0);
    do_op("3/9", 8'd3, 8'd9, 1'b0);
    do_op("255/1", 8'd255, 8'd1, 1'b0);
    do_op("0/13", 8'd0, 8'd13, 1'b0);

    // A start pulse while busy must neither disturb the result nor queue a second run.
    launch(8'd200, 8'd10, 1'b0);
    step; step; step;
    start_i = 1'b1;
    dividend_i = 8'd9;
    divisor_i = 8'd3;
    step;
    start_i = 1'b0;
    wait_done("ignore", 8'd200, 8'd10, 1'b0, 5);
    idle_check("ignore", W + 3);

    launch(8'd200, 8'd10, 1'b0);
    step; step; step;
    reset = 1'b1;
    step;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    check("midrst quotient", 32'(quotient_o), 32'd0);
    check("midrst remainder", 32'(remainder_o), 32'd0);
    check("midrst dbz", 32'(div_by_zero_o), 32'd0);
    reset = 1'b0;
    idle_check("midrst", W + 2);
    do_op("17/5", 8'd17, 8'd5, 1'b0);

`ifdef DIVISOR_SIGNED_EN
    do_op("s -7/2", 8'hF9, 8'd2, 1'b1);
    do_op("s 7/-2", 8'd7, 8'hFE, 1'b1);
    do_op("s -128/-1", 8'h80, 8'hFF, 1'b1);
    do_op("s -5/0", 8'hFB, 8'd0, 1'b1);
    do_op("u 249/2", 8'hF9, 8'd2, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
`ifdef DIVISOR_SIGNED_EN
      sm = 1'($urandom);
`else
      sm = 1'b0;
`endif
      do_op("random", a, b, sm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
